// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, LSB-first data, optional parity, stop).
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit;
  logic                 parity_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // rx_prev holds the level seen on the previous tick, so a start needs a real 1->0 edge
  // and a held-low break cannot retrigger reception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_prev    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_q   <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q   <= 1'b0;
`endif
      if (baud_tick) begin
        rx_prev <= rx_s;
        case (state)
          IDLE: begin
            if (rx_prev && !rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt   <= '0;
              parity_bit <= rx_s;
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif
          STOP: begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (!rx_s) begin
                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (^{shift_reg, parity_bit}) begin
                parity_q <= 1'b1;
`endif
              end else begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule
